piso_stream: RTL and testbench
==============================

PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk input 1, the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst input 1, asynchronous active-high reset; clock clk.
REQ-004 The block SHALL have port in_data input WIDTH, the parallel word to serialize.
REQ-005 The block SHALL have port in_valid input 1, meaning in_data is offered.
REQ-006 The block SHALL have port in_msb_first input 1, bit order for the offered word (1 = MSB first, 0 = LSB first).
REQ-007 The block SHALL have port in_ready output 1, meaning the block can accept a word this cycle.
REQ-008 The block SHALL have port ser_out output 1, the registered serial data bit.
REQ-009 The block SHALL have port ser_valid output 1, meaning ser_out carries a frame bit this cycle.
REQ-010 The block SHALL have port frame_start output 1, high during the first bit of each frame.
REQ-011 The block SHALL have port done output 1, high during the last bit of each frame.
REQ-012 The block SHALL have port busy output 1, high while a frame is shifting or a word is held.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_msb_first is captured with the word.
REQ-014 Storage SHALL be a shift register plus one holding register; in_ready SHALL equal NOT hold_full, a registered flag.
REQ-015 States SHALL be IDLE and SHIFT; IDLE->SHIFT on accept; SHIFT->IDLE after the last bit when the holding register is empty and no accept occurs.
REQ-016 Latency SHALL be one cycle: the first frame bit is on ser_out in the cycle after the accepting edge.
REQ-017 A frame SHALL occupy FRAME_LEN consecutive cycles with ser_valid=1; FRAME_LEN = WIDTH, or WIDTH+1 with parity (REQ-028).
REQ-018 LSB-first order SHALL emit bit 0 up to bit WIDTH-1; MSB-first order SHALL emit bit WIDTH-1 down to bit 0.
REQ-019 The bit counter SHALL be $clog2(WIDTH+2) bits wide, SHALL count 0..FRAME_LEN-1, and SHALL wrap to 0 on the last bit.
REQ-020 An accept in SHIFT SHALL load the holding register; an accept in IDLE SHALL load the shift register directly.
REQ-021 On the last bit with the holding register full, the held word SHALL move to the shift register and its first bit SHALL follow with no gap; hold_full clears and in_ready rises the next cycle.
REQ-022 On the last bit with the holding register empty and an accept on the same edge, the new word SHALL start gaplessly.
REQ-023 ser_out SHALL be 0 whenever ser_valid=0.
REQ-024 in_data and in_msb_first SHALL be ignored when no accept occurs.

Reset
REQ-025 On rst, in_ready SHALL be 1 and ser_out, ser_valid, frame_start, done, and busy SHALL all be 0; state SHALL be IDLE; the counter SHALL be 0; and hold_full SHALL be 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately and discard the held word; no done pulse SHALL occur.
REQ-027 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 With macro PISO_STREAM_PARITY_EN defined, each frame SHALL append one even-parity bit (XOR of all WIDTH data bits) after the data bits, and done SHALL mark the parity bit.
REQ-029 Without PISO_STREAM_PARITY_EN, there SHALL be no parity logic, and FRAME_LEN SHALL be WIDTH.

Verification
REQ-030 Scenario 1, WIDTH=16, no parity: 0xA5C3 accepted LSB-first -> ser_out 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on 16 consecutive cycles starting one cycle after the accept; frame_start on bit 1 only; done on bit 16 only.
REQ-031 Scenario 2: 0xA5C3 accepted MSB-first -> ser_out 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
REQ-032 Scenario 3: three words 0xFFFF, 0x0000, 0x8001 offered back-to-back with in_valid held -> 48 contiguous ser_valid cycles; in_ready low while the hold is full; three done pulses spaced 16 cycles apart.
REQ-033 Scenario 4: rst asserted at bit 7 of 0x1234 with 0x5678 held -> all outputs at reset values immediately; no done pulse; the next frame after release carries only newly accepted data.
REQ-034 Scenario 5, PISO_STREAM_PARITY_EN defined: 0xA5C3 -> 17-bit frame with parity bit 0; 0x0001 -> parity bit 1; done on bit 17.
REQ-035 Scenario 6: accept on the same edge as the last bit with the hold empty -> the new word's first bit follows immediately, and ser_valid never drops.

Source files
------------

// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer: one WIDTH-bit word per frame, LSB- or MSB-first per word.
// Latency: first frame bit on ser_out one cycle after the accepting edge; back-to-back frames are gapless.
// Backpressure: one-word holding register; in_ready = !hold_full. Optional macro PISO_STREAM_PARITY_EN appends even parity.
module piso_stream #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_msb_first,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

`ifdef PISO_STREAM_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic             shift_msb;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_msb;
    logic             hold_full;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    // Bit idx of the frame for a given word; shifts avoid over-wide index selects.
    function automatic logic frame_bit(input logic [WIDTH-1:0] word,
                                       input logic             msb,
                                       input logic [CNT_W-1:0] idx);
        logic [WIDTH-1:0] lsb_sh;
        logic [WIDTH-1:0] msb_sh;
        lsb_sh = word >> idx;
        msb_sh = word << idx;
`ifdef PISO_STREAM_PARITY_EN
        if (idx == CNT_W'(WIDTH))
            return ^word;
`endif
        return msb ? msb_sh[WIDTH-1] : lsb_sh[0];
    endfunction

    assign in_ready = !hold_full;
    assign accept   = in_valid && in_ready;
    assign cnt_nxt  = cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            shift_msb   <= 1'b0;
            hold_reg    <= '0;
            hold_msb    <= 1'b0;
            hold_full   <= 1'b0;
            cnt         <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                state       <= SHIFT;
                shift_reg   <= in_data;
                shift_msb   <= in_msb_first;
                cnt         <= '0;
                ser_out     <= frame_bit(in_data, in_msb_first, '0);
                ser_valid   <= 1'b1;
                frame_start <= 1'b1;
                done        <= 1'b0;
                busy        <= 1'b1;
            end
        end else if (cnt != LAST_IDX) begin
            cnt         <= cnt_nxt;
            ser_out     <= frame_bit(shift_reg, shift_msb, cnt_nxt);
            frame_start <= 1'b0;
            done        <= (cnt_nxt == LAST_IDX);
            if (accept) begin
                hold_reg  <= in_data;
                hold_msb  <= in_msb_first;
                hold_full <= 1'b1;
            end
        end else if (hold_full) begin
            // Last bit with a word waiting: chain it in with no idle cycle.
            shift_reg   <= hold_reg;
            shift_msb   <= hold_msb;
            hold_full   <= 1'b0;
            cnt         <= '0;
            ser_out     <= frame_bit(hold_reg, hold_msb, '0);
            frame_start <= 1'b1;
            done        <= 1'b0;
        end else if (accept) begin
            shift_reg   <= in_data;
            shift_msb   <= in_msb_first;
            cnt         <= '0;
            ser_out     <= frame_bit(in_data, in_msb_first, '0);
            frame_start <= 1'b1;
            done        <= 1'b0;
        end else begin
            state       <= IDLE;
            cnt         <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream (WIDTH=16): table-driven single frames plus
// back-to-back, mid-frame reset and same-edge restart sequences.
module tb_piso_stream;
    localparam int WIDTH = 16;
`ifdef PISO_STREAM_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_msb_first;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             done;
    logic             busy;

    piso_stream #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_msb_first (in_msb_first),
        .in_ready     (in_ready),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .frame_start  (frame_start),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // seq[i] is the i-th emitted data bit; par is the expected parity bit.
    typedef struct {
        logic [15:0] data;
        logic        msb;
        logic [15:0] seq;
        logic        par;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [15:0] seq, input logic par, input int i);
        return (i < WIDTH) ? seq[i] : par;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check($sformatf("%s_ser_valid", tag), ser_valid, 0);
        check($sformatf("%s_ser_out", tag), ser_out, 0);
        check($sformatf("%s_frame_start", tag), frame_start, 0);
        check($sformatf("%s_done", tag), done, 0);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_in_ready", tag), in_ready, 1);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        in_data      = v.data;
        in_msb_first = v.msb;
        in_valid     = 1'b1;
        check($sformatf("%s_rdy", tag), in_ready, 1);
        tick;
        in_valid     = 1'b0;
        in_data      = 16'($urandom);
        in_msb_first = 1'($urandom);
        for (int i = 0; i < FL; i++) begin
            check($sformatf("%s_vld%0d", tag, i), ser_valid, 1);
            check($sformatf("%s_bit%0d", tag, i), ser_out, exp_bit(v.seq, v.par, i));
            check($sformatf("%s_fs%0d", tag, i), frame_start, (i == 0));
            check($sformatf("%s_done%0d", tag, i), done, (i == FL - 1));
            if (i == 0)
                check($sformatf("%s_busy", tag), busy, 1);
            tick;
        end
        check_idle_outputs($sformatf("%s_end", tag));
    endtask

    initial begin
        logic [15:0] w3[3];
        int   idx, nvalid, nbad, nrdy_bad, drop;
        int   dpos[$];
        logic acc;
        logic exp_rdy;

        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b0};
        vecs[1] = '{16'hA5C3, 1'b1, 16'hC3A5, 1'b0};
        vecs[2] = '{16'h0001, 1'b0, 16'h0001, 1'b1};
        vecs[3] = '{16'h0001, 1'b1, 16'h8000, 1'b1};
        vecs[4] = '{16'h1234, 1'b1, 16'h2C48, 1'b1};
        vecs[5] = '{16'hF00F, 1'b0, 16'hF00F, 1'b0};

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_msb_first = 1'b0;
        #12;
        check_idle_outputs("reset");

        // First accept lands on the first rising edge after release.
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 6; t++)
            run_frame(vecs[t], $sformatf("vec%0d", t));

        // Back-to-back words with in_valid held.
        w3[0] = 16'hFFFF; w3[1] = 16'h0000; w3[2] = 16'h8001;
        idx = 0; nvalid = 0; nbad = 0; nrdy_bad = 0;
        in_valid = 1'b1; in_data = w3[0]; in_msb_first = 1'b0;
        for (int k = 1; k <= 3 * FL + 8; k++) begin
            acc = in_valid && in_ready;
            tick;
            if (acc) idx++;
            if (idx >= 3) in_valid = 1'b0;
            else          in_data  = w3[idx];
            if (ser_valid) begin
                nvalid++;
                if (k > 3 * FL)
                    nbad++;
                else if (ser_out !== exp_bit(w3[(k-1)/FL], ^w3[(k-1)/FL], (k-1) % FL))
                    nbad++;
            end else if (k <= 3 * FL) begin
                nbad++;
            end
            if (done) dpos.push_back(k);
            exp_rdy = (k == 1) || (k == FL + 1) || (k >= 2 * FL + 1);
            if (in_ready !== exp_rdy) nrdy_bad++;
        end
        check("b2b_valid_cycles", nvalid, 3 * FL);
        check("b2b_bad_bits", nbad, 0);
        check("b2b_in_ready_bad", nrdy_bad, 0);
        check("b2b_done_count", dpos.size(), 3);
        if (dpos.size() == 3) begin
            check("b2b_done0", dpos[0], FL);
            check("b2b_done1", dpos[1], 2 * FL);
            check("b2b_done2", dpos[2], 3 * FL);
        end
        check_idle_outputs("b2b_end");

        // Reset at bit 7 of 0x1234 with 0x5678 held.
        in_valid = 1'b1; in_data = 16'h1234; in_msb_first = 1'b0;
        tick;
        in_data = 16'h5678;
        tick;
        in_valid = 1'b0;
        check("rst_hold_full", in_ready, 0);
        for (int k = 0; k < 5; k++) tick;
        check("rst_pre_vld", ser_valid, 1);
        check("rst_pre_bit7", ser_out, 0);
        check("rst_pre_done", done, 0);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        tick;
        tick;
        check_idle_outputs("rst_held");
        @(negedge clk);
        rst = 1'b0;
        run_frame(vecs[2], "post_rst");

        // New word accepted on the same edge as the last bit, hold empty.
        drop = 0; nbad = 0;
        in_valid = 1'b1; in_data = 16'h00FF; in_msb_first = 1'b0;
        tick;
        in_valid = 1'b0;
        for (int k = 1; k <= 2 * FL; k++) begin
            if (!ser_valid) drop++;
            if (k <= FL) begin
                if (ser_out !== exp_bit(16'h00FF, 1'b0, k - 1)) nbad++;
            end else begin
                if (ser_out !== exp_bit(16'h2C48, 1'b1, k - 1 - FL)) nbad++;
            end
            if (k == FL) begin
                check("chain_done_first", done, 1);
                in_valid = 1'b1; in_data = 16'h1234; in_msb_first = 1'b1;
            end
            if (k == FL + 1) begin
                check("chain_frame_start", frame_start, 1);
                in_valid = 1'b0;
            end
            if (k == 2 * FL)
                check("chain_done_second", done, 1);
            tick;
        end
        check("chain_valid_drops", drop, 0);
        check("chain_bad_bits", nbad, 0);
        check_idle_outputs("chain_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
